// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-stage results in, register-file write port and status out.
// Optional second-history forwarding outputs exist only when MEM_WB_FWD2_EN is defined.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              in_regWrite;
  logic              in_memToReg;
  logic [2:0]        in_loadType;
  logic [REG_AW-1:0] in_writeReg;
  logic [DATA_W-1:0] in_aluResult;
  logic [DATA_W-1:0] in_memData;

  logic              regWrite;
  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              wb_valid;
  logic              misalign;
  logic [CNT_W-1:0]  retired_count;
`ifdef MEM_WB_FWD2_EN
  logic              fwd2_valid;
  logic [REG_AW-1:0] fwd2_reg;
  logic [DATA_W-1:0] fwd2_data;
`endif

  modport master (
    output in_valid, in_regWrite, in_memToReg, in_loadType, in_writeReg, in_aluResult, in_memData,
`ifdef MEM_WB_FWD2_EN
    input  fwd2_valid, fwd2_reg, fwd2_data,
`endif
    input  regWrite, writeReg, writeData, wb_valid, misalign, retired_count
  );

  modport slave (
    input  in_valid, in_regWrite, in_memToReg, in_loadType, in_writeReg, in_aluResult, in_memData,
`ifdef MEM_WB_FWD2_EN
    output fwd2_valid, fwd2_reg, fwd2_data,
`endif
    output regWrite, writeReg, writeData, wb_valid, misalign, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB register with load extract/extend, r0/misalign write suppression and a saturating retire counter.
// One-cycle latency; stall holds, flush bubbles (flush wins). MEM_WB_FWD2_EN adds a second-history forwarding slot.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall,
  input  logic           flush,
  mem_wb_stage_if.slave  bus
);
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic [1:0]        offset;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [DATA_W-1:0] nextData;
  logic              nextMisalign;
  logic              nextRegWrite;

  logic              wbValidQ;
  logic              regWriteQ;
  logic              misalignQ;
  logic [REG_AW-1:0] writeRegQ;
  logic [DATA_W-1:0] writeDataQ;
  logic [CNT_W-1:0]  retiredQ;

  always_comb begin
    offset       = bus.in_aluResult[1:0];
    loadByte     = bus.in_memData[{offset, 3'b000} +: 8];
    loadHalf     = offset[1] ? bus.in_memData[31:16] : bus.in_memData[15:0];
    nextData     = bus.in_aluResult;
    nextMisalign = 1'b0;
    if (bus.in_memToReg) begin
      // Reserved load types fall into the lw path.
      case (bus.in_loadType)
        LT_LB:  nextData = {{(DATA_W-8){loadByte[7]}}, loadByte};
        LT_LBU: nextData = {{(DATA_W-8){1'b0}}, loadByte};
        LT_LH: begin
          nextData     = {{(DATA_W-16){loadHalf[15]}}, loadHalf};
          nextMisalign = offset[0];
        end
        LT_LHU: begin
          nextData     = {{(DATA_W-16){1'b0}}, loadHalf};
          nextMisalign = offset[0];
        end
        default: begin
          nextData     = bus.in_memData;
          nextMisalign = (offset != 2'b00);
        end
      endcase
    end
    nextMisalign = nextMisalign & bus.in_valid;
    nextRegWrite = bus.in_valid & bus.in_regWrite & (bus.in_writeReg != '0) & ~nextMisalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValidQ   <= 1'b0;
      regWriteQ  <= 1'b0;
      misalignQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else if (flush) begin
      wbValidQ   <= 1'b0;
      regWriteQ  <= 1'b0;
      misalignQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else if (!stall) begin
      wbValidQ   <= bus.in_valid;
      regWriteQ  <= nextRegWrite;
      misalignQ  <= nextMisalign;
      writeRegQ  <= bus.in_writeReg;
      writeDataQ <= nextData;
    end
  end

  // The WB occupant retires whenever its slot is vacated, including by a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredQ <= '0;
    end else if (wbValidQ && (flush || !stall) && (retiredQ != '1)) begin
      retiredQ <= retiredQ + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.regWrite      = regWriteQ;
  assign bus.writeReg      = writeRegQ;
  assign bus.writeData     = writeDataQ;
  assign bus.wb_valid      = wbValidQ;
  assign bus.misalign      = misalignQ;
  assign bus.retired_count = retiredQ;

`ifdef MEM_WB_FWD2_EN
  logic              fwd2ValidQ;
  logic [REG_AW-1:0] fwd2RegQ;
  logic [DATA_W-1:0] fwd2DataQ;

  // Previous WB contents shift down whenever the WB slot is replaced; flush does not clear history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd2ValidQ <= 1'b0;
      fwd2RegQ   <= '0;
      fwd2DataQ  <= '0;
    end else if (flush || !stall) begin
      fwd2ValidQ <= regWriteQ;
      fwd2RegQ   <= writeRegQ;
      fwd2DataQ  <= writeDataQ;
    end
  end

  assign bus.fwd2_valid = fwd2ValidQ;
  assign bus.fwd2_reg   = fwd2RegQ;
  assign bus.fwd2_data  = fwd2DataQ;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a negedge-sampling register file and a narrow-counter twin for saturation.
module tb_mem_wb_stage;
  logic clk;
  logic rst_n;
  logic stall;
  logic flush;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] expCnt = 0;
  logic        slotValid = 0;
  logic [31:0] rf [32];

  mem_wb_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dutIf ();
  mem_wb_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  satIf ();

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) uDut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(dutIf)
  );
  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) uSat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(satIf)
  );

  assign satIf.in_valid     = dutIf.in_valid;
  assign satIf.in_regWrite  = dutIf.in_regWrite;
  assign satIf.in_memToReg  = dutIf.in_memToReg;
  assign satIf.in_loadType  = dutIf.in_loadType;
  assign satIf.in_writeReg  = dutIf.in_writeReg;
  assign satIf.in_aluResult = dutIf.in_aluResult;
  assign satIf.in_memData   = dutIf.in_memData;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: writes on negedge, r0 deliberately not protected here.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (dutIf.regWrite) begin
      rf[dutIf.writeReg] <= dutIf.writeData;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setIn(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] mem);
    dutIf.in_valid     = v;
    dutIf.in_regWrite  = rw;
    dutIf.in_memToReg  = m2r;
    dutIf.in_loadType  = lt;
    dutIf.in_writeReg  = wr;
    dutIf.in_aluResult = alu;
    dutIf.in_memData   = mem;
  endtask

  // Advances one posedge and updates the expected slot/counter state.
  task automatic tick();
    if (rst_n) begin
      if (slotValid && (flush || !stall) && expCnt != 32'hFFFF_FFFF) expCnt++;
      if (flush) slotValid = 1'b0;
      else if (!stall) slotValid = dutIf.in_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkCtl(input string tag, input logic rw, input logic v, input logic m);
    checkVal({tag, ".regWrite"}, {31'b0, dutIf.regWrite}, {31'b0, rw});
    checkVal({tag, ".wb_valid"}, {31'b0, dutIf.wb_valid}, {31'b0, v});
    checkVal({tag, ".misalign"}, {31'b0, dutIf.misalign}, {31'b0, m});
    checkVal({tag, ".count"}, dutIf.retired_count, expCnt);
    checkVal({tag, ".satCount"}, {30'b0, satIf.retired_count}, (expCnt > 3) ? 32'd3 : expCnt);
  endtask

  task automatic checkOut(input string tag, input logic rw, input logic [4:0] wr,
                          input logic [31:0] wd, input logic v, input logic m);
    checkCtl(tag, rw, v, m);
    checkVal({tag, ".writeReg"}, {27'b0, dutIf.writeReg}, {27'b0, wr});
    checkVal({tag, ".writeData"}, dutIf.writeData, wd);
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  a;
    logic [31:0] exp;
  } loadVec_t;

  loadVec_t loads [6] = '{
    '{3'b001, 2'd3, 32'hFFFF_FF80},
    '{3'b010, 2'd3, 32'h0000_0080},
    '{3'b011, 2'd2, 32'hFFFF_80FF},
    '{3'b100, 2'd0, 32'h0000_7F01},
    '{3'b001, 2'd1, 32'h0000_007F},
    '{3'b111, 2'd0, 32'h80FF_7F01}
  };

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    setIn(1, 1, 0, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
    #1;
    checkOut("asyncRst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOut("rst", 0, 0, 0, 0, 0);
    end

    rst_n = 1'b1;
    tick();
    checkOut("alu", 1, 5, 32'h0000_1234, 1, 0);
    @(negedge clk); #1;
    checkVal("rf.r5", rf[5], 32'h0000_1234);

    foreach (loads[i]) begin
      setIn(1, 1, 1, loads[i].lt, 5'd7, 32'h0000_1000 | {30'b0, loads[i].a}, 32'h80FF_7F01);
      tick();
      checkOut($sformatf("load%0d", i), 1, 7, loads[i].exp, 1, 0);
    end

    setIn(1, 1, 0, 3'b001, 5'd8, 32'h1234_5603, 32'h80FF_7F01);
    tick();
    checkOut("aluIgnoresLt", 1, 8, 32'h1234_5603, 1, 0);

    setIn(1, 1, 1, 3'b011, 5'd7, 32'h0000_1001, 32'h80FF_7F01);
    tick();
    checkCtl("misLh", 0, 1, 1);
    setIn(1, 1, 1, 3'b000, 5'd7, 32'h0000_1002, 32'h80FF_7F01);
    tick();
    checkCtl("misLw", 0, 1, 1);

    setIn(0, 1, 1, 3'b000, 5'd3, 32'h0000_0002, 32'h0);
    tick();
    checkCtl("invalid", 0, 0, 0);

    setIn(1, 1, 0, 3'b000, 5'd0, 32'hDEAD_BEEF, 32'h0);
    tick();
    checkOut("r0", 0, 0, 32'hDEAD_BEEF, 1, 0);
    @(negedge clk); #1;
    checkVal("rf.r0", rf[0], 32'h0);

    setIn(1, 1, 0, 3'b000, 5'd9, 32'hAAAA_0009, 32'h0);
    tick();
    checkOut("preStall", 1, 9, 32'hAAAA_0009, 1, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setIn(1, 1, 1, 3'b001, 5'(10 + i), $urandom, $urandom);
      tick();
      checkOut($sformatf("stall%0d", i), 1, 9, 32'hAAAA_0009, 1, 0);
    end
    @(negedge clk); #1;
    checkVal("rf.r9", rf[9], 32'hAAAA_0009);

    flush = 1'b1;
    tick();
    checkOut("stallFlush", 0, 0, 0, 0, 0);
    stall = 1'b0;
    tick();
    checkOut("flushEmpty", 0, 0, 0, 0, 0);
    flush = 1'b0;

    setIn(1, 1, 0, 3'b000, 5'd11, 32'h0000_0077, 32'h0);
    tick();
    checkOut("preAsync", 1, 11, 32'h0000_0077, 1, 0);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    expCnt = 0;
    slotValid = 1'b0;
    #1;
    checkOut("rstMidStall", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;

    for (int i = 0; i < 5; i++) begin
      setIn(1, 1, 0, 3'b000, 5'(20 + i), 32'(100 + i), 32'h0);
      tick();
      checkOut($sformatf("retire%0d", i), 1, 5'(20 + i), 32'(100 + i), 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback select/align logic.
- Feeds the register file's write port (writeReg, writeData, regWrite); the register file samples on negedge clk.
- Captures MEM-stage results on posedge and performs load byte/half extraction and sign/zero extension.
- Suppresses illegal writes and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; captures on posedge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold current contents (hazard unit).
- flush  in  1  insert bubble (exception/branch squash).
- in_valid  in  1  MEM stage holds a real instruction.
- in_regWrite  in  1  instruction writes a register.
- in_memToReg  in  1  1 = load data, 0 = ALU result.
- in_loadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others reserved.
- in_writeReg  in  REG_AW  destination register.
- in_aluResult  in  DATA_W  ALU result, or the effective address for loads.
- in_memData  in  DATA_W  raw aligned word from data memory.
- regWrite  out  1  write enable to the register file.
- writeReg  out  REG_AW  destination register to the register file.
- writeData  out  DATA_W  final writeback value.
- wb_valid  out  1  the WB slot holds a real instruction.
- misalign  out  1  the WB slot's load was misaligned; its write is suppressed.
- retired_count  out  CNT_W  number of valid instructions that left WB.

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Internal registers 0.
- Reset release: takes effect at the next posedge.
- Priority at posedge: flush > stall > load.
  - flush=1: wb_valid←0, regWrite←0, misalign←0. writeReg/writeData are don't-care but set to 0.
  - stall=1 (flush=0): all state held; retired_count does not increment.
  - Otherwise: latch the inputs.
- Latency: one cycle. Inputs at posedge N appear on the outputs after posedge N. The register file writes them at the following negedge.
- Load extraction uses byte offset a = in_aluResult[1:0]:
  - lb/lbu: byte in_memData[8a+7:8a], sign- or zero-extended.
  - lh/lhu: half at a[1] (bits 15:0 or 31:16), sign- or zero-extended.
  - lh/lhu with a[0]=1: misaligned.
  - lw with a≠00: misaligned.
- Misaligned load: misalign=1, regWrite=0, wb_valid=1 (the instruction still retires).
- Reserved in_loadType with in_memToReg=1: treated as lw.
- in_memToReg=0: writeData=in_aluResult; in_loadType is ignored.
- regWrite = in_valid & in_regWrite & (in_writeReg≠0) & ~misalign. A write to r0 is never issued, but writeData still carries the value.
- in_valid=0: regWrite=0, wb_valid=0.
- retired_count:
  - Increments at each posedge where wb_valid=1 and stall=0, i.e. the slot is being vacated.
  - Increments even when flush=1 in that cycle (the WB occupant itself retires).
  - Saturates at all-ones; never wraps.
- Stall held for multiple cycles: outputs remain constant. regWrite stays asserted, so the register file re-writes the same value each negedge; this is harmless and required.
- Reset asserted mid-stall or mid-flush: all outputs go to 0 immediately, without waiting for a clock edge.

Optional Feature:
- Macro: MEM_WB_FWD2_EN.
- Defined: adds outputs fwd2_valid (1), fwd2_reg (REG_AW), fwd2_data (DATA_W).
  - These form a second-history slot holding the previous WB contents, shifted in whenever WB loads (no stall).
  - Gives the forwarding unit a second-oldest source.
  - fwd2_valid = previous slot's regWrite. It is cleared by reset; flush does not clear it.
- Undefined: those ports do not exist, and no extra registers are built.

Test Plan:
- Reset then ALU write. Stimulus: rst_n low 3 cycles, then in_valid=1, in_regWrite=1, in_memToReg=0, in_writeReg=5, in_aluResult=0x0000_1234. Response: outputs 0 during reset; after one posedge regWrite=1, writeReg=5, writeData=0x1234; regfile r5=0x1234 after the negedge.
- Byte/half loads with in_memData=0x80FF_7F01:
  - lb a=3 → 0xFFFF_FF80.
  - lbu a=3 → 0x0000_0080.
  - lh a=2 → 0xFFFF_80FF.
  - lhu a=0 → 0x0000_7F01.
  - lb a=1 → 0x0000_007F.
- Misalign: lh a=1 → misalign=1, regWrite=0, wb_valid=1. lw a=2 → same response.
- Stall/flush:
  - stall=1 for 3 cycles with changing inputs → outputs frozen and retired_count unchanged.
  - stall=1 and flush=1 together → wb_valid=0 after the edge, and retired_count+1 if the slot was valid.
- Writes to r0: in_writeReg=0 with in_regWrite=1, in_aluResult=0xDEAD_BEEF → regWrite=0, writeData=0xDEAD_BEEF, regfile r0 remains 0.
- Counter saturation: force retired_count to 0xFFFF_FFFE, retire 3 instructions → count ends at 0xFFFF_FFFF.
